bus_rr_arbiter: RTL and testbench
=================================

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 Parameter NCORES, default 2: number of requesting cores; SHALL be a power of two in 2..4.
REQ-002 Parameter MAX_HOLD, default 8: maximum owned cycles before forced release; SHALL be in 1..255.
REQ-003 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 i_init_done  in  1  memory-system initialisation complete; no grant SHALL be issued while low.
REQ-006 i_req  in  NCORES  per-core bus request, level, held by the core while it wants the bus.
REQ-007 i_idle  in  NCORES  per-core instruction-boundary flag (core in decode state); the bus is safe to take away when high.
REQ-008 i_sys_busy  in  1  shared resource busy (DRAM busy, UART not ready or data busy, ORed upstream).
REQ-009 o_grant  out  clog2(NCORES)  index of the core driving the shared bus, registered.
REQ-010 o_grant_vld  out  1  high only in state OWN.
REQ-011 o_busy  out  NCORES  per-core busy stall; combinational from state, o_grant and i_sys_busy.
REQ-012 o_hold_cnt  out  8  cycles the current owner has held the bus in OWN.

Function
REQ-013 States SHALL be IDLE, SETTLE, OWN, HANDOVER, encoded in 2 bits.
REQ-014 o_busy[k] SHALL be i_sys_busy when state==OWN and k==o_grant; 1 in every other case.
REQ-015 IDLE: when i_init_done && |i_req, o_grant SHALL load the first requester searched cyclically from (o_grant+1) mod NCORES and the FSM SHALL go to SETTLE; otherwise remain IDLE.
REQ-016 SETTLE: exactly one cycle; o_hold_cnt SHALL clear to 0; next state OWN.
REQ-017 OWN: o_hold_cnt SHALL increment by 1 per cycle, saturating at 255.
REQ-018 Release condition SHALL be i_idle[o_grant] && !i_sys_busy && (!i_req[o_grant] || o_hold_cnt >= MAX_HOLD-1).
REQ-019 On release: if any other core requests, go to HANDOVER; else if the owner still requests, stay OWN with o_hold_cnt cleared to 0; else go to IDLE.
REQ-020 Release SHALL never occur while i_sys_busy is high or the owner is not at an instruction boundary, regardless of o_hold_cnt.
REQ-021 HANDOVER: exactly one cycle with o_grant unchanged; then o_grant SHALL load the next requester searched cyclically from (o_grant+1) and the FSM SHALL go to SETTLE; if no core then requests, go to IDLE with o_grant unchanged.
REQ-022 Round-robin search SHALL wrap from NCORES-1 to 0 and SHALL select the owner itself only when no other core requests.
REQ-023 Handover latency SHALL be 2 cycles of all-busy (HANDOVER and SETTLE) between the last OWN cycle of one core and the first OWN cycle of the next.
REQ-024 If i_init_done falls, the FSM SHALL finish the current state and then stay in IDLE until it rises again.
REQ-025 Request bits of non-owners SHALL have no effect on o_busy.

Reset
REQ-026 RST high SHALL immediately set state IDLE, o_grant 0, o_hold_cnt 0, o_grant_vld 0, and all o_busy bits 1, including mid-OWN or mid-HANDOVER.
REQ-027 After RST falls, the first grant SHALL go to core 1 if requesting; otherwise to the next requester cyclically.

Verification
REQ-028 NCORES=2, MAX_HOLD=4, init_done=1, i_req=2'b01, idle=2'b11, sys_busy=0 -> grant 0, SETTLE then OWN; o_busy=2'b10; o_hold_cnt cycles 0..3, then restarts at 0 with no handover.
REQ-029 i_req=2'b11 steady, idle=2'b11 -> grant alternates 0/1 (or 1/0) every 4 OWN cycles, with 2 all-busy cycles (o_busy=2'b11) between owners.
REQ-030 Owner 0 at hold_cnt=3 with i_sys_busy=1 for 5 cycles -> no release; o_hold_cnt reaches 8; handover on the first cycle with sys_busy=0 && idle[0]=1.
REQ-031 Core 1 drops i_req during HANDOVER with core 0 still requesting -> core 0 re-granted via SETTLE; if both drop -> IDLE, o_grant_vld=0.
REQ-032 RST asserted asynchronously mid-OWN (owner 1, hold_cnt=2) -> same-cycle o_busy=2'b11, o_grant=0, state IDLE.
REQ-033 i_init_done=0 with i_req=2'b11 for 10 cycles -> state IDLE, o_busy=2'b11; on rising i_init_done -> grant 1 after 1 cycle.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter
// Round-robin owner of a shared memory/peripheral bus for NCORES cores.
// One core at a time owns the bus. The bus is taken back only when that core
// sits at an instruction boundary and the shared resource is not mid-access.
// A change of owner always passes through two all-stall cycles (HANDOVER, SETTLE)
// so the old owner's last bus cycle is finished before the new owner drives it.
//
// Handshake: i_req[k] is a level. Core k holds it high for as long as it wants the bus.
// Core k may use the bus on any cycle where o_grant_vld && o_grant == k && !o_busy[k].
// There is no separate acknowledge. Dropping i_req while owning lets the bus go
// at the next instruction boundary.
//
// Ports:
//   CLK          clock, all state updates on the rising edge
//   RST          asynchronous, active-high reset
//   i_init_done  memory system initialised; no new grant is issued while low
//   i_req        per-core bus request (level)
//   i_idle       per-core "at instruction boundary" flag
//   i_sys_busy   shared resource busy (ORed upstream)
//   o_grant      index of the current/last owner (registered)
//   o_grant_vld  high only while in OWN
//   o_busy       per-core stall: only the owner in OWN sees i_sys_busy, everyone else is stalled
//   o_hold_cnt   cycles the current owner has spent in OWN (saturating)
//   o_state      FSM state for debug/checkers (0 IDLE, 1 SETTLE, 2 OWN, 3 HANDOVER)
module bus_rr_arbiter #(
    parameter int NCORES   = 2,
    parameter int MAX_HOLD = 8,
    localparam int GW      = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_init_done,
    input  logic [NCORES-1:0] i_req,
    input  logic [NCORES-1:0] i_idle,
    input  logic              i_sys_busy,
    output logic [GW-1:0]     o_grant,
    output logic              o_grant_vld,
    output logic [NCORES-1:0] o_busy,
    output logic [7:0]        o_hold_cnt,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SETTLE   = 2'd1,
        S_OWN      = 2'd2,
        S_HANDOVER = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [7:0]        hold_q,  hold_d;

    logic              rr_found;
    logic [GW-1:0]     rr_pick;
    logic [NCORES-1:0] owner_mask;
    logic              others_req;
    logic              release_ok;

    // Cyclic search starting at grant_q+1. The owner itself is visited last,
    // so it is picked only when nobody else is asking. NCORES is a power of two,
    // so wrap-around is just GW-bit overflow.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = grant_q;
        for (int i = 1; i <= NCORES; i++) begin
            logic [GW-1:0] idx;
            idx = grant_q + GW'(i);
            if (!rr_found && i_req[idx]) begin
                rr_found = 1'b1;
                rr_pick  = idx;
            end
        end
    end

    assign owner_mask = NCORES'(1) << grant_q;
    assign others_req = |(i_req & ~owner_mask);

    // The bus may only be taken away at an instruction boundary with no access
    // in flight. Hold count alone never forces a release.
    assign release_ok = i_idle[grant_q] && !i_sys_busy &&
                        (!i_req[grant_q] || (hold_q >= HOLD_LIMIT));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (i_init_done && (|i_req)) begin
                    grant_d = rr_pick;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                hold_d  = '0;
                state_d = S_OWN;
            end
            S_OWN: begin
                hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
                if (release_ok) begin
                    // With init_done low the current tenure ends and nothing new starts.
                    if (!i_init_done) begin
                        state_d = S_IDLE;
                    end else if (others_req) begin
                        state_d = S_HANDOVER;
                    end else if (i_req[grant_q]) begin
                        // Sole requester: a fresh tenure without the two-cycle gap.
                        hold_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_HANDOVER: begin
                // Requests are re-sampled here, so a core that gave up during
                // HANDOVER is skipped. The old owner can be re-granted.
                if (i_init_done && rr_found) begin
                    grant_d = rr_pick;
                    state_d = S_SETTLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = '1;
        for (int k = 0; k < NCORES; k++) begin
            if ((state_q == S_OWN) && (grant_q == GW'(k))) begin
                o_busy[k] = i_sys_busy;
            end
        end
    end

    assign o_grant     = grant_q;
    assign o_grant_vld = (state_q == S_OWN);
    assign o_hold_cnt  = hold_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter with NCORES=2, MAX_HOLD=4.
// Inputs change and outputs are checked on the falling edge. The DUT updates
// on the rising edge.
module tb_bus_rr_arbiter;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SET  = 2'd1;
    localparam logic [1:0] ST_OWN  = 2'd2;
    localparam logic [1:0] ST_HND  = 2'd3;

    logic       CLK = 1'b0;
    logic       RST;
    logic       i_init_done;
    logic [1:0] i_req;
    logic [1:0] i_idle;
    logic       i_sys_busy;
    logic       o_grant;
    logic       o_grant_vld;
    logic [1:0] o_busy;
    logic [7:0] o_hold_cnt;
    logic [1:0] o_state;

    int n_checks = 0;
    int n_fail   = 0;

    bus_rr_arbiter #(.NCORES(2), .MAX_HOLD(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .i_init_done (i_init_done),
        .i_req       (i_req),
        .i_idle      (i_idle),
        .i_sys_busy  (i_sys_busy),
        .o_grant     (o_grant),
        .o_grant_vld (o_grant_vld),
        .o_busy      (o_busy),
        .o_hold_cnt  (o_hold_cnt),
        .o_state     (o_state)
    );

    always #5 CLK = ~CLK;

    // Observed vector layout: {state, grant, grant_vld, busy} (6 bits)

    task automatic test_reset();
        RST = 1'b1; i_init_done = 1'b1; i_req = 2'b00; i_idle = 2'b11; i_sys_busy = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant, o_grant_vld, o_busy, o_hold_cnt} !== {ST_IDLE, 1'b0, 1'b0, 2'b11, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_state got=%b exp=%b", {o_state, o_grant, o_grant_vld, o_busy, o_hold_cnt},
                     {ST_IDLE, 1'b0, 1'b0, 2'b11, 8'd0});
        end
        RST = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant_vld, o_busy} !== {ST_IDLE, 1'b0, 2'b11}) begin
            n_fail++;
            $display("FAIL reset_no_req got=%b exp=%b", {o_state, o_grant_vld, o_busy}, {ST_IDLE, 1'b0, 2'b11});
        end
    endtask

    // Sole requester core 0: SETTLE, then hold count 0..3 repeating with no handover.
    task automatic test_single_owner();
        i_req = 2'b01;
        @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant, o_grant_vld, o_busy} !== {ST_SET, 1'b0, 1'b0, 2'b11}) begin
            n_fail++;
            $display("FAIL single_settle got=%b exp=%b", {o_state, o_grant, o_grant_vld, o_busy}, {ST_SET, 1'b0, 1'b0, 2'b11});
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            n_checks++;
            if ({o_state, o_grant, o_grant_vld, o_busy, o_hold_cnt} !== {ST_OWN, 1'b0, 1'b1, 2'b10, 8'(i % 4)}) begin
                n_fail++;
                $display("FAIL single_own[%0d] got=%b exp=%b", i, {o_state, o_grant, o_grant_vld, o_busy, o_hold_cnt},
                         {ST_OWN, 1'b0, 1'b1, 2'b10, 8'(i % 4)});
            end
        end
        i_req = 2'b00;
        @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant, o_grant_vld, o_busy} !== {ST_IDLE, 1'b0, 1'b0, 2'b11}) begin
            n_fail++;
            $display("FAIL single_release got=%b exp=%b", {o_state, o_grant, o_grant_vld, o_busy}, {ST_IDLE, 1'b0, 1'b0, 2'b11});
        end
    endtask

    // Both request steadily: owners alternate every 4 OWN cycles with 2 all-busy cycles between.
    task automatic test_alternate();
        logic [1:0] exp_st [14];
        logic       exp_g  [14];
        logic [7:0] exp_h  [14];
        logic [1:0] exp_b;
        exp_st = '{ST_SET, ST_OWN, ST_OWN, ST_OWN, ST_OWN, ST_HND, ST_SET,
                   ST_OWN, ST_OWN, ST_OWN, ST_OWN, ST_HND, ST_SET, ST_OWN};
        exp_g  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_h  = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd0,
                   8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0};
        i_req = 2'b11;
        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            exp_b = (exp_st[i] != ST_OWN) ? 2'b11 : (exp_g[i] ? 2'b01 : 2'b10);
            n_checks++;
            if ({o_state, o_grant, o_grant_vld, o_busy} !== {exp_st[i], exp_g[i], exp_st[i] == ST_OWN, exp_b} ||
                (exp_st[i] == ST_OWN && o_hold_cnt !== exp_h[i])) begin
                n_fail++;
                $display("FAIL alternate[%0d] got=%b hold=%0d exp=%b hold=%0d", i,
                         {o_state, o_grant, o_grant_vld, o_busy}, o_hold_cnt,
                         {exp_st[i], exp_g[i], exp_st[i] == ST_OWN, exp_b}, exp_h[i]);
            end
        end
        i_req = 2'b00;
        @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant, o_grant_vld, o_busy} !== {ST_IDLE, 1'b1, 1'b0, 2'b11}) begin
            n_fail++;
            $display("FAIL alternate_idle got=%b exp=%b", {o_state, o_grant, o_grant_vld, o_busy}, {ST_IDLE, 1'b1, 1'b0, 2'b11});
        end
    endtask

    // sys_busy and a missing instruction boundary both block release past the hold limit.
    task automatic test_sys_busy_hold();
        i_req = 2'b11;
        @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant} !== {ST_SET, 1'b0}) begin
            n_fail++;
            $display("FAIL busy_settle got=%b exp=%b", {o_state, o_grant}, {ST_SET, 1'b0});
        end
        for (int h = 0; h < 4; h++) begin
            @(negedge CLK);
            n_checks++;
            if ({o_state, o_grant, o_busy, o_hold_cnt} !== {ST_OWN, 1'b0, 2'b10, 8'(h)}) begin
                n_fail++;
                $display("FAIL busy_pre[%0d] got=%b exp=%b", h, {o_state, o_grant, o_busy, o_hold_cnt}, {ST_OWN, 1'b0, 2'b10, 8'(h)});
            end
        end
        i_sys_busy = 1'b1;
        for (int h = 4; h <= 8; h++) begin
            @(negedge CLK);
            n_checks++;
            if ({o_state, o_grant, o_grant_vld, o_busy, o_hold_cnt} !== {ST_OWN, 1'b0, 1'b1, 2'b11, 8'(h)}) begin
                n_fail++;
                $display("FAIL busy_stall[%0d] got=%b exp=%b", h, {o_state, o_grant, o_grant_vld, o_busy, o_hold_cnt},
                         {ST_OWN, 1'b0, 1'b1, 2'b11, 8'(h)});
            end
        end
        i_sys_busy = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant, o_grant_vld, o_busy} !== {ST_HND, 1'b0, 1'b0, 2'b11}) begin
            n_fail++;
            $display("FAIL busy_handover got=%b exp=%b", {o_state, o_grant, o_grant_vld, o_busy}, {ST_HND, 1'b0, 1'b0, 2'b11});
        end
        @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant, o_busy} !== {ST_SET, 1'b1, 2'b11}) begin
            n_fail++;
            $display("FAIL busy_settle1 got=%b exp=%b", {o_state, o_grant, o_busy}, {ST_SET, 1'b1, 2'b11});
        end
        @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant, o_busy, o_hold_cnt} !== {ST_OWN, 1'b1, 2'b01, 8'd0}) begin
            n_fail++;
            $display("FAIL busy_own1 got=%b exp=%b", {o_state, o_grant, o_busy, o_hold_cnt}, {ST_OWN, 1'b1, 2'b01, 8'd0});
        end
        i_idle = 2'b01;
        for (int h = 1; h <= 4; h++) begin
            @(negedge CLK);
            n_checks++;
            if ({o_state, o_grant, o_busy, o_hold_cnt} !== {ST_OWN, 1'b1, 2'b01, 8'(h)}) begin
                n_fail++;
                $display("FAIL not_idle[%0d] got=%b exp=%b", h, {o_state, o_grant, o_busy, o_hold_cnt}, {ST_OWN, 1'b1, 2'b01, 8'(h)});
            end
        end
        i_idle = 2'b11;
        @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant} !== {ST_HND, 1'b1}) begin
            n_fail++;
            $display("FAIL idle_handover got=%b exp=%b", {o_state, o_grant}, {ST_HND, 1'b1});
        end
        i_req = 2'b00;
        @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant, o_grant_vld, o_busy} !== {ST_IDLE, 1'b1, 1'b0, 2'b11}) begin
            n_fail++;
            $display("FAIL busy_end_idle got=%b exp=%b", {o_state, o_grant, o_grant_vld, o_busy}, {ST_IDLE, 1'b1, 1'b0, 2'b11});
        end
    endtask

    // Requests dropped during HANDOVER: old owner re-granted, or back to IDLE.
    task automatic test_handover_drop();
        i_req = 2'b11;
        @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant} !== {ST_SET, 1'b0}) begin
            n_fail++;
            $display("FAIL drop_settle got=%b exp=%b", {o_state, o_grant}, {ST_SET, 1'b0});
        end
        repeat (4) @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant, o_hold_cnt} !== {ST_OWN, 1'b0, 8'd3}) begin
            n_fail++;
            $display("FAIL drop_own3 got=%b exp=%b", {o_state, o_grant, o_hold_cnt}, {ST_OWN, 1'b0, 8'd3});
        end
        @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant} !== {ST_HND, 1'b0}) begin
            n_fail++;
            $display("FAIL drop_handover got=%b exp=%b", {o_state, o_grant}, {ST_HND, 1'b0});
        end
        i_req = 2'b01;
        @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant, o_busy} !== {ST_SET, 1'b0, 2'b11}) begin
            n_fail++;
            $display("FAIL drop_regrant got=%b exp=%b", {o_state, o_grant, o_busy}, {ST_SET, 1'b0, 2'b11});
        end
        @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant, o_busy, o_hold_cnt} !== {ST_OWN, 1'b0, 2'b10, 8'd0}) begin
            n_fail++;
            $display("FAIL drop_own0 got=%b exp=%b", {o_state, o_grant, o_busy, o_hold_cnt}, {ST_OWN, 1'b0, 2'b10, 8'd0});
        end
        i_req = 2'b11;
        repeat (4) @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant} !== {ST_HND, 1'b0}) begin
            n_fail++;
            $display("FAIL drop_handover2 got=%b exp=%b", {o_state, o_grant}, {ST_HND, 1'b0});
        end
        i_req = 2'b00;
        @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant, o_grant_vld, o_busy} !== {ST_IDLE, 1'b0, 1'b0, 2'b11}) begin
            n_fail++;
            $display("FAIL drop_both_idle got=%b exp=%b", {o_state, o_grant, o_grant_vld, o_busy}, {ST_IDLE, 1'b0, 1'b0, 2'b11});
        end
    endtask

    // Reset asserted mid-OWN acts immediately; the first grant after reset goes to core 1.
    task automatic test_async_reset();
        i_req = 2'b10;
        repeat (4) @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant, o_busy, o_hold_cnt} !== {ST_OWN, 1'b1, 2'b01, 8'd2}) begin
            n_fail++;
            $display("FAIL areset_pre got=%b exp=%b", {o_state, o_grant, o_busy, o_hold_cnt}, {ST_OWN, 1'b1, 2'b01, 8'd2});
        end
        #2 RST = 1'b1;
        #1;
        n_checks++;
        if ({o_state, o_grant, o_grant_vld, o_busy, o_hold_cnt} !== {ST_IDLE, 1'b0, 1'b0, 2'b11, 8'd0}) begin
            n_fail++;
            $display("FAIL areset_now got=%b exp=%b", {o_state, o_grant, o_grant_vld, o_busy, o_hold_cnt},
                     {ST_IDLE, 1'b0, 1'b0, 2'b11, 8'd0});
        end
        @(negedge CLK);
        RST = 1'b0;
        i_req = 2'b11;
        @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant} !== {ST_SET, 1'b1}) begin
            n_fail++;
            $display("FAIL areset_first_grant got=%b exp=%b", {o_state, o_grant}, {ST_SET, 1'b1});
        end
        i_req = 2'b00;
        @(negedge CLK);
        @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant, o_grant_vld} !== {ST_IDLE, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL areset_end got=%b exp=%b", {o_state, o_grant, o_grant_vld}, {ST_IDLE, 1'b1, 1'b0});
        end
    endtask

    // init_done low blocks new grants; dropping it mid-OWN ends the tenure in IDLE.
    task automatic test_init_done();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        i_init_done = 1'b0;
        i_req = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            n_checks++;
            if ({o_state, o_grant_vld, o_busy} !== {ST_IDLE, 1'b0, 2'b11}) begin
                n_fail++;
                $display("FAIL init_low[%0d] got=%b exp=%b", i, {o_state, o_grant_vld, o_busy}, {ST_IDLE, 1'b0, 2'b11});
            end
        end
        i_init_done = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant} !== {ST_SET, 1'b1}) begin
            n_fail++;
            $display("FAIL init_rise_grant got=%b exp=%b", {o_state, o_grant}, {ST_SET, 1'b1});
        end
        @(negedge CLK);
        i_init_done = 1'b0;
        repeat (3) @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant, o_hold_cnt} !== {ST_OWN, 1'b1, 8'd3}) begin
            n_fail++;
            $display("FAIL init_fall_own got=%b exp=%b", {o_state, o_grant, o_hold_cnt}, {ST_OWN, 1'b1, 8'd3});
        end
        @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant, o_grant_vld, o_busy} !== {ST_IDLE, 1'b1, 1'b0, 2'b11}) begin
            n_fail++;
            $display("FAIL init_fall_idle got=%b exp=%b", {o_state, o_grant, o_grant_vld, o_busy}, {ST_IDLE, 1'b1, 1'b0, 2'b11});
        end
        i_init_done = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({o_state, o_grant} !== {ST_SET, 1'b0}) begin
            n_fail++;
            $display("FAIL init_regrant got=%b exp=%b", {o_state, o_grant}, {ST_SET, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_single_owner();
        test_alternate();
        test_sys_busy_hold();
        test_handover_drop();
        test_async_reset();
        test_init_done();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
